// File: rtl/music_sequencer.sv
// music_sequencer: song sequencer and fixed-priority arbiter for the
// square-wave note player. Grants the shared note ROM to one requester at a
// time, walks that song's notes at a fixed step rate, and feeds the player.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req[2:0]      play-request pulses, req[2] highest priority
//   grant[2:0]    one-hot owner of the ROM/player, 0 when idle
//   busy          high whenever the sequencer is not idle
//   rom_addr[9:0] {song_id, note_index}, registered
//   rom_data[7:0] ROM read data, valid one cycle after rom_addr changes
//   fullnote[7:0] note to the player, bits[5:0]==0 is a rest
//   note_en       player gate
//   done/done_id  one-cycle completion pulse and id of the finished song
module music_sequencer #(
  parameter int unsigned TICK_LEN = 4194304,
  parameter int unsigned GAP_LEN  = 262144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] grant,
  output logic       busy,
  output logic [9:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] fullnote,
  output logic       note_en,
  output logic       done,
  output logic [1:0] done_id
);

  // One extra bit so TICK_LEN-GAP_LEN fits even when GAP_LEN is 0.
  localparam int unsigned CW = $clog2(TICK_LEN + 1);
  localparam logic [CW-1:0] LAST   = CW'(TICK_LEN - 1);
  localparam logic [CW-1:0] ON_LEN = CW'(TICK_LEN - GAP_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_DONE
  } state_t;

  state_t        state;
  logic [2:0]    pending;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    top_id;
  logic [2:0]    top_onehot;
  logic          higher;
  logic          take;
  logic [2:0]    clr;

  always_comb begin
    top_id = 2'd0;
    if (pending[2])      top_id = 2'd2;
    else if (pending[1]) top_id = 2'd1;
    top_onehot = 3'b001 << top_id;

    // Current song id lives in the upper ROM address bits.
    higher = 1'b0;
    case (rom_addr[9:8])
      2'd0:    higher = |pending[2:1];
      2'd1:    higher = pending[2];
      default: higher = 1'b0;
    endcase

    take = ((state == S_IDLE) && (pending != '0)) ||
           ((state == S_PLAY) && (cnt == LAST) && higher);
    clr      = take ? top_onehot : '0;
    cnt_next = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pending  <= '0;
      cnt      <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      rom_addr <= '0;
      fullnote <= '0;
      note_en  <= 1'b0;
      done     <= 1'b0;
      done_id  <= '0;
    end else begin
      // A new request in the grant cycle survives the clear.
      pending <= (pending & ~clr) | req;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          note_en <= 1'b0;
          if (take) begin
            grant    <= top_onehot;
            rom_addr <= {top_id, 8'h00};
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          if (rom_data == 8'hFF) begin
            done    <= 1'b1;
            done_id <= rom_addr[9:8];
            state   <= S_DONE;
          end else begin
            fullnote <= rom_data;
            cnt      <= '0;
            note_en  <= (rom_data[5:0] != '0);
            state    <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (cnt == LAST) begin
            note_en <= 1'b0;
            if (take) begin
              grant    <= top_onehot;
              rom_addr <= {top_id, 8'h00};
              state    <= S_FETCH;
            end else if (rom_addr[7:0] == 8'hFF) begin
              done    <= 1'b1;
              done_id <= rom_addr[9:8];
              state   <= S_DONE;
            end else begin
              rom_addr[7:0] <= rom_addr[7:0] + 8'd1;
              state         <= S_FETCH;
            end
          end else begin
            cnt     <= cnt_next;
            note_en <= (cnt_next < ON_LEN) && (fullnote[5:0] != '0);
          end
        end
        S_DONE: begin
          grant    <= '0;
          fullnote <= '0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a note-slot reference model.
module tb_music_sequencer;
  localparam int unsigned T = 8;
  localparam int unsigned G = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] grant;
  logic       busy;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] fullnote;
  logic       note_en;
  logic       done;
  logic [1:0] done_id;

  always #5 clk = ~clk;

  music_sequencer #(.TICK_LEN(T), .GAP_LEN(G)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data), .fullnote(fullnote),
    .note_en(note_en), .done(done), .done_id(done_id)
  );

  logic [7:0] mem [1024];
  always @(posedge clk) rom_data <= mem[rom_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a song is a sequence of note slots of T+2 cycles;
  // slot position 0 is the fetch cycle, 1 the load, 2..T+1 the sounding part.
  bit       m_active = 0;
  bit       m_done   = 0;
  int       m_id = 0, m_idx = 0, m_pos = 0, m_addr = 0, m_done_id = 0;
  bit [7:0] m_note = 0;
  bit [2:0] m_pend = 0;

  function automatic int top_bit(input bit [2:0] p);
    return p[2] ? 2 : (p[1] ? 1 : 0);
  endfunction

  task automatic model_step();
    bit [2:0] clr;
    int       start;
    clr   = 0;
    start = -1;
    if (rst) begin
      m_active = 0; m_done = 0; m_id = 0; m_idx = 0; m_pos = 0;
      m_addr = 0; m_done_id = 0; m_note = 0; m_pend = 0;
      return;
    end
    if (!m_active) begin
      if (m_pend != 0) start = top_bit(m_pend);
    end else if (m_done) begin
      m_active = 0; m_done = 0; m_note = 0;
    end else if (m_pos == 0) begin
      m_pos = 1;
    end else if (m_pos == 1) begin
      if (mem[m_addr] == 8'hFF) begin
        m_done = 1; m_done_id = m_id;
      end else begin
        m_note = mem[m_addr]; m_pos = 2;
      end
    end else if (m_pos == T + 1) begin
      if ((m_pend >> (m_id + 1)) != 0) start = top_bit(m_pend);
      else if (m_idx == 255) begin
        m_done = 1; m_done_id = m_id;
      end else begin
        m_idx++; m_addr++; m_pos = 0;
      end
    end else begin
      m_pos++;
    end
    if (start >= 0) begin
      m_active = 1; m_id = start; m_idx = 0; m_pos = 0; m_addr = start * 256;
      clr = 3'(1 << start);
    end
    m_pend = (m_pend & ~clr) | req;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    check("grant", grant, m_active ? (1 << m_id) : 0);
    check("busy", busy, m_active);
    check("rom_addr", rom_addr, m_addr);
    check("fullnote", fullnote, m_note);
    check("note_en", note_en, m_active && !m_done && m_pos >= 2 &&
          (m_pos - 2) < int'(T - G) && m_note[5:0] != 0);
    check("done", done, m_done);
    check("done_id", done_id, m_done_id);
  end

  int done_log[$];
  always @(negedge clk) if (done) done_log.push_back(int'(done_id));

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] r);
    req = r;
    tick(1);
    req = '0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && done_log.size() < n; i++) tick(1);
    check(tag, done_log.size(), n);
    tick(3);
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 1024; a++) mem[a] = 8'hFF;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    clear_mem();

    // Reset then idle
    tick(3);
    rst = 1'b0;
    tick(50);
    check("idle_busy", busy, 0);
    check("idle_addr", rom_addr, 0);

    // Single song with a rest note
    mem[0] = 8'h15; mem[1] = 8'h00; mem[2] = 8'hFF;
    done_log.delete();
    req = 3'b001;
    tick(1);
    req = '0;
    tick(1);
    check("s2_grant", grant, 3'b001);
    check("s2_addr", rom_addr, 10'h000);
    tick(2);
    check("s2_note", fullnote, 8'h15);
    for (int i = 0; i < 8; i++) begin
      check("s2_gate", note_en, i < 6);
      tick(1);
    end
    tick(12);
    check("s2_done", done, 1);
    check("s2_done_id", done_id, 0);
    tick(1);
    check("s2_busy", busy, 0);
    tick(5);
    check("s2_ndone", done_log.size(), 1);

    // Preemption by song 2
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04; mem[4] = 8'hFF;
    mem[512] = 8'h20; mem[513] = 8'hFF;
    done_log.delete();
    pulse(3'b001);
    for (int i = 0; i < 100 && !(m_idx == 1 && m_pos == 3); i++) tick(1);
    check("s3_reach", m_idx == 1 && m_pos == 3, 1);
    pulse(3'b100);
    for (int i = 0; i < 100 && grant != 3'b100; i++) tick(1);
    check("s3_grant", grant, 3'b100);
    check("s3_addr", rom_addr, 10'h200);
    wait_dones(1, 200, "s3_wait");
    tick(60);
    check("s3_ndone", done_log.size(), 1);
    if (done_log.size() > 0) check("s3_id", done_log[0], 2);

    // Deferred low-priority request
    mem[256] = 8'h31; mem[257] = 8'h32; mem[258] = 8'hFF;
    done_log.delete();
    pulse(3'b010);
    for (int i = 0; i < 100 && !(m_id == 1 && m_pos == 4); i++) tick(1);
    pulse(3'b001);
    for (int i = 0; i < 200 && done !== 1'b1; i++) tick(1);
    check("s4_done", done, 1);
    check("s4_done_id", done_id, 1);
    tick(2);
    check("s4_grant", grant, 3'b001);
    wait_dones(2, 300, "s4_wait");
    if (done_log.size() > 1) check("s4_id1", done_log[1], 0);

    // Simultaneous requests plus a repeat of song 1
    done_log.delete();
    pulse(3'b111);
    for (int i = 0; i < 200 && !(grant == 3'b010 && note_en); i++) tick(1);
    check("s5_reach", grant, 3'b010);
    pulse(3'b010);
    wait_dones(4, 600, "s5_wait");
    if (done_log.size() == 4) begin
      check("s5_o0", done_log[0], 2);
      check("s5_o1", done_log[1], 1);
      check("s5_o2", done_log[2], 1);
      check("s5_o3", done_log[3], 0);
    end

    // Reset mid-note with a pending request outstanding
    done_log.delete();
    pulse(3'b001);
    for (int i = 0; i < 100 && note_en !== 1'b1; i++) tick(1);
    pulse(3'b010);
    for (int i = 0; i < 100 && note_en !== 1'b1; i++) tick(1);
    check("s6_gate", note_en, 1);
    rst = 1'b1;
    req = 3'b100;
    tick(1);
    rst = 1'b0;
    req = '0;
    check("s6_grant", grant, 0);
    check("s6_busy", busy, 0);
    check("s6_addr", rom_addr, 0);
    check("s6_note", fullnote, 0);
    check("s6_gate0", note_en, 0);
    check("s6_done", done, 0);
    check("s6_done_id", done_id, 0);
    tick(30);
    check("s6_quiet", busy, 0);
    check("s6_ndone", done_log.size(), 0);

    // Unterminated song ends by index wrap
    for (int a = 256; a < 512; a++) mem[a] = 8'($urandom_range(0, 63));
    done_log.delete();
    pulse(3'b010);
    wait_dones(1, 3000, "s7_wait");
    if (done_log.size() > 0) check("s7_id", done_log[0], 1);

    // Randomized traffic over random short songs
    for (int r = 0; r < 20; r++) begin
      clear_mem();
      for (int s = 0; s < 3; s++) begin
        int len;
        len = $urandom_range(0, 4);
        for (int k = 0; k < len; k++)
          mem[s * 256 + k] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 254));
      end
      for (int c = 0; c < 300; c++) begin
        req = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        rst = ($urandom_range(0, 199) == 0);
        tick(1);
      end
      req = '0;
      rst = 1'b0;
      for (int i = 0; i < 2000 && (m_active || m_pend != 0); i++) tick(1);
      check("rnd_drain", m_active || m_pend != 0, 0);
      tick(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
